// File: rtl/signed_sub_sat_accumulator_if.sv
// Sample-in / result-out handshake bundle for the saturating subtract accumulator.
// The master side feeds samples and consumes results. The slave side is the accumulator.
interface signed_sub_sat_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sat_hi;
  logic             sat_lo;
  logic [7:0]       sat_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat_hi, sat_lo, sat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat_hi, sat_lo, sat_count
  );
endinterface

// File: rtl/signed_sub_sat_accumulator.sv
// Frame accumulator: acc <= sat(acc - sample) over N_SAMPLES accepted samples.
// It then holds the frame result until the consumer takes it.
module signed_sub_sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int N_SAMPLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  signed_sub_sat_accumulator_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  localparam logic [7:0]       N_LAST  = 8'(N_SAMPLES - 1);
  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {clamp_hi, clamp_lo, result} of a - b using a one-bit-wider signed difference.
  function automatic logic [WIDTH+1:0] sat_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      if (diff[WIDTH] == 1'b0) begin
        return {1'b1, 1'b0, ACC_MAX};
      end else begin
        return {1'b0, 1'b1, ACC_MIN};
      end
    end else begin
      return {2'b00, diff[WIDTH-1:0]};
    end
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic [7:0]       sat_count_q, sat_count_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;

  logic             accept_s;
  logic             deliver_s;
  logic             last_s;
  logic             hi_s;
  logic             lo_s;
  logic [WIDTH-1:0] res_s;

  assign accept_s  = bus.in_valid && (state_q == ST_ACC);
  assign deliver_s = bus.out_ready && (state_q == ST_OUT);
  assign last_s    = accept_s && (cnt_q == N_LAST);
  assign {hi_s, lo_s, res_s} = sat_sub(acc_q, bus.in_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC:  state_d = last_s ? ST_OUT : ST_ACC;
        ST_OUT:  state_d = bus.out_ready ? ST_ACC : ST_OUT;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    bus.in_ready  = (state_q == ST_ACC);
    bus.out_valid = (state_q == ST_OUT);
    bus.out_data  = out_data_q;
    bus.sat_hi    = sat_hi_q;
    bus.sat_lo    = sat_lo_q;
    bus.sat_count = sat_count_q;
  end

  // Datapath next state. held_q keeps the last delivered result so that an aborted frame never shows.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    held_d      = held_q;
    sat_count_d = sat_count_q;
    sat_hi_d    = 1'b0;
    sat_lo_d    = 1'b0;
    if (clear) begin
      acc_d       = '0;
      cnt_d       = 8'd0;
      sat_count_d = 8'd0;
      if (state_q == ST_OUT) begin
        out_data_d = held_q;
      end else begin
        out_data_d = out_data_q;
      end
    end else if (deliver_s) begin
      acc_d       = '0;
      cnt_d       = 8'd0;
      sat_count_d = 8'd0;
      held_d      = out_data_q;
    end else if (accept_s) begin
      acc_d    = res_s;
      sat_hi_d = hi_s;
      sat_lo_d = lo_s;
      if ((hi_s || lo_s) && (sat_count_q != 8'hFF)) begin
        sat_count_d = sat_count_q + 8'd1;
      end else begin
        sat_count_d = sat_count_q;
      end
      if (last_s) begin
        cnt_d      = 8'd0;
        out_data_d = res_s;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      out_data_q  <= '0;
      held_q      <= '0;
      sat_count_q <= 8'd0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      held_q      <= held_d;
      sat_count_q <= sat_count_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
    end
  end

endmodule

// File: doc/signed_sub_sat_accumulator.md
SIGNED_SUB_SAT_ACCUMULATOR -- requirements
Module: signed_sub_sat_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning two's-complement width of sample and accumulator.
REQ-002 SHALL have parameter N_SAMPLES, default 4, meaning accepted samples per result frame (range 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clear  input  1  synchronous frame abort.
REQ-006 in_valid  input  1  sample present.
REQ-007 in_data  input  WIDTH  signed subtrahend.
REQ-008 in_ready  output  1  block accepts sample this cycle.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_data  output  WIDTH  signed frame result.
REQ-012 sat_hi  output  1  one-cycle pulse: last update clamped to max.
REQ-013 sat_lo  output  1  one-cycle pulse: last update clamped to min.
REQ-014 sat_count  output  8  clamp events in current frame.

Function
REQ-015 SHALL implement two states, ACC and OUT; reset state ACC.
REQ-016 In ACC, in_ready SHALL be 1 and out_valid 0; in OUT, in_ready SHALL be 0 and out_valid 1.
REQ-017 Accept = in_valid & in_ready; on accept, acc SHALL become sat(acc - in_data), using WIDTH+1-bit signed difference.
REQ-018 sat(): difference > 2^(WIDTH-1)-1 -> max (7 for WIDTH 4), sat_hi pulses; < -2^(WIDTH-1) -> min (-8), sat_lo pulses; otherwise exact.
REQ-019 sat_hi/sat_lo SHALL be registered, asserted exactly the cycle after the clamping accept, never both.
REQ-020 sat_count SHALL increment per clamp event, saturate at 255, and clear on frame start.
REQ-021 Accepted-sample counter SHALL reach N_SAMPLES -> next state OUT, out_data = final acc (same edge, latency 1 cycle from last accept).
REQ-022 out_data, sat_count SHALL hold stable while out_valid & !out_ready.
REQ-023 On out_valid & out_ready: state ACC, acc = 0, sample counter = 0, sat_count = 0; no sample accepted that cycle.
REQ-024 clear SHALL take priority over all: state ACC, acc = 0, counter = 0, sat_count = 0, flags 0, any pending result discarded; sample presented with clear is dropped.
REQ-025 in_data = min with acc >= 0 SHALL clamp to max (e.g. 0 - (-8) -> 7).
REQ-026 out_data in ACC SHALL hold the last delivered result (0 after reset).

Reset
REQ-027 rst_n low SHALL immediately force: state ACC, acc 0, counter 0, out_data 0, out_valid 0, in_ready 1 after release, sat_hi 0, sat_lo 0, sat_count 0.
REQ-028 Reset mid-frame or mid-OUT SHALL discard all progress; first accept after release starts a new frame.

Verification (WIDTH 4, N_SAMPLES 4)
REQ-029 Feed 1,2,3,-1 back-to-back, out_ready 1 -> out_data -5, sat_count 0, no flag pulses, out_valid one cycle.
REQ-030 Feed 5,5,5,-8 -> acc -5,-8(sat_lo),-8(sat_lo),0; out_data 0, sat_count 2.
REQ-031 Feed -8,-1,2,2 -> 7(sat_hi),7(sat_hi),5,3; out_data 3, sat_count 2.
REQ-032 Complete frame with out_ready 0 for 3 cycles -> out_valid, out_data, sat_count stable, in_ready 0; accepted on 4th cycle, in_ready 1 next cycle.
REQ-033 Two samples accepted, then clear with in_valid 1 -> acc 0, counter 0, that sample dropped; next 4 samples form a full frame.
REQ-034 rst_n pulsed low asynchronously (between edges) during OUT -> out_valid 0 and out_data 0 immediately, frame lost.
